// File: rtl/conv_pkg.sv
// Shared types and defaults for the converter config-link transmitter.
// Holds the FSM encoding and small elaboration-time helpers.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LAT   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    localparam int CONV_WORDS   = 4;
    localparam int DEF_BIT_DIV  = 24;
    localparam int DEF_GAP_BITS = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int frame_cycles(input int words,
                                        input int bit_div,
                                        input int gap_bits);
        return words * (2 + 32 * bit_div + gap_bits * 2 * bit_div) + 1;
    endfunction

endpackage

// File: rtl/conv_bit_timer.sv
// Half-bit tick generator: pulses tick_o once every BIT_DIV cycles
// while clr_i is low, restarting from zero whenever clr_i is high.
module conv_bit_timer
    import conv_pkg::*;
#(
    parameter int BIT_DIV = DEF_BIT_DIV
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr_i,
    output logic tick_o
);

    localparam int          W    = cnt_w(BIT_DIV);
    localparam logic [W-1:0] LAST = W'(BIT_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_cfg_tx.sv
// Reads register words through the 1-cycle read port and shifts each
// one MSB-first onto the SCK/SDA/OE config link, once per START.
module conv_cfg_tx
    import conv_pkg::*;
#(
    parameter int NUM_WORDS = CONV_WORDS,
    parameter int BIT_DIV   = DEF_BIT_DIV,
    parameter int GAP_BITS  = DEF_GAP_BITS
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic        ABORT,
    output logic        RE_B,
    output logic [1:0]  ADD_B,
    input  logic [15:0] DAT_B,
    output logic        CFG_SCK,
    output logic        CFG_SDA,
    output logic        CFG_OE,
    output logic        BUSY,
    output logic        DONE
);

    localparam int           GW       = cnt_w(2 * GAP_BITS);
    localparam logic [GW-1:0] GAP_LAST = GW'(2 * GAP_BITS - 1);
    localparam logic [1:0]   IDX_LAST = 2'(NUM_WORDS - 1);

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    sr_q, sr_d;
    logic [3:0]     bit_q, bit_d;
    logic           half_q, half_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           word_end;
    logic           tick;
    logic           tmr_clr;

    assign tmr_clr = !((state_q == ST_SHIFT) || (state_q == ST_GAP));

    conv_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_timer (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .clr_i  (tmr_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        half_d   = half_q;
        gap_d    = gap_q;
        word_end = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RD;
                    idx_d   = '0;
                end
            end
            ST_RD: begin
                state_d = ST_LAT;
            end
            ST_LAT: begin
                sr_d    = DAT_B;
                bit_d   = 4'd15;
                half_d  = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    half_d = !half_q;
                    if (half_q) begin
                        if (bit_q == 4'd0) begin
                            gap_d = '0;
                            if (GAP_BITS == 0) begin
                                word_end = 1'b1;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end else begin
                            bit_d = bit_q - 4'd1;
                            sr_d  = {sr_q[14:0], 1'b0};
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        word_end = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (word_end) begin
            if (idx_q == IDX_LAST) begin
                state_d = ST_FIN;
            end else begin
                idx_d   = idx_q + 2'd1;
                state_d = ST_RD;
            end
        end

        // Abort overrides any transition computed above, including START.
        if (ABORT) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            bit_d   = '0;
            half_d  = 1'b0;
            gap_d   = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
        end
    end

    // Outputs decode registered state only, so reset clears them at once.
    always_comb begin
        RE_B    = (state_q == ST_RD);
        ADD_B   = (state_q == ST_RD) ? idx_q : 2'b00;
        CFG_SCK = (state_q == ST_SHIFT) && half_q;
        CFG_SDA = (state_q == ST_SHIFT) && sr_q[15];
        CFG_OE  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
        BUSY    = (state_q != ST_IDLE);
        DONE    = (state_q == ST_FIN);
    end

endmodule

// File: tb/tb_conv_cfg_tx.sv
// Scoreboard bench for conv_cfg_tx with a byte-addressed register file model.
// Stimulus pushes expected reads/words/DONEs; a monitor pops and compares.
module tb_conv_cfg_tx;
    import conv_pkg::*;

    localparam int BD = 2;
    localparam int GB = 2;
    localparam int NW = 4;

    logic        CLOCK;
    logic        RESET;
    logic        START;
    logic        ABORT;
    logic        RE_B;
    logic [1:0]  ADD_B;
    logic [15:0] DAT_B;
    logic        CFG_SCK;
    logic        CFG_SDA;
    logic        CFG_OE;
    logic        BUSY;
    logic        DONE;

    logic [7:0]  mem [0:7];
    logic [15:0] dat_q;

    logic [1:0]  exp_addr[$];
    logic [15:0] exp_word[$];
    int          exp_done;
    int          n_cmp;
    int          n_err;

    conv_cfg_tx #(
        .NUM_WORDS (NW),
        .BIT_DIV   (BD),
        .GAP_BITS  (GB)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .START   (START),
        .ABORT   (ABORT),
        .RE_B    (RE_B),
        .ADD_B   (ADD_B),
        .DAT_B   (DAT_B),
        .CFG_SCK (CFG_SCK),
        .CFG_SDA (CFG_SDA),
        .CFG_OE  (CFG_OE),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Word n is {byte 2n, byte 2n+1}, returned one cycle after RE_B.
    always @(posedge CLOCK) begin
        if (RE_B) begin
            dat_q <= {mem[{ADD_B, 1'b0}], mem[{ADD_B, 1'b1}]};
        end
    end
    assign DAT_B = dat_q;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic        ps = 1'b0;
        logic        pd = 1'b0;
        logic [15:0] sh = '0;
        int          nb = 0;
        forever begin
            @(negedge CLOCK);
            if (RE_B) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_re_b: add_b=%0d none expected",
                             ADD_B);
                end else begin
                    chk("add_b", 32'(ADD_B), 32'(exp_addr.pop_front()));
                end
            end
            if (DONE) begin
                n_cmp++;
                if (exp_done == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: done=1 none expected");
                end else begin
                    exp_done--;
                end
            end
            if (!CFG_OE) nb = 0;
            if (CFG_SCK && ps) chk("sda_stable", 32'(CFG_SDA), 32'(pd));
            if (CFG_SCK && !ps) begin
                chk("oe_at_rise", 32'(CFG_OE), 32'd1);
                sh = {sh[14:0], CFG_SDA};
                nb++;
                if (nb == 16) begin
                    nb = 0;
                    if (exp_word.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word: got %0h none expected",
                                 sh);
                    end else begin
                        chk("word", 32'(sh), 32'(exp_word.pop_front()));
                    end
                end
            end
            ps = CFG_SCK;
            pd = CFG_SDA;
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        mem[a] = d;
    endtask

    task automatic push_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < NW; i++) exp_addr.push_back(2'(i));
        exp_word.push_back(w0);
        exp_word.push_back(w1);
        exp_word.push_back(w2);
        exp_word.push_back(w3);
        exp_done++;
    endtask

    task automatic start();
        @(posedge CLOCK); #1;
        START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (BUSY && n < 2000) begin
            @(posedge CLOCK); #1;
            n++;
        end
        chk("frame_end_timeout", 32'(BUSY), 32'd0);
    endtask

    task automatic wait_rises(input int cnt);
        int   c = 0;
        int   t = 0;
        logic p = CFG_SCK;
        while (c < cnt && t < 5000) begin
            @(posedge CLOCK); #1;
            t++;
            if (CFG_SCK && !p) c++;
            p = CFG_SCK;
        end
        chk("rise_timeout", 32'(c), 32'(cnt));
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_done_left"}, 32'(exp_done), 32'd0);
        chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        chk({tag, "_word_left"}, 32'(exp_word.size()), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_re_b"}, 32'(RE_B), 32'd0);
        chk({tag, "_add_b"}, 32'(ADD_B), 32'd0);
        chk({tag, "_sck"}, 32'(CFG_SCK), 32'd0);
        chk({tag, "_sda"}, 32'(CFG_SDA), 32'd0);
        chk({tag, "_oe"}, 32'(CFG_OE), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        int n;
        int bn;
        START    = 1'b0;
        ABORT    = 1'b0;
        RESET    = 1'b0;
        exp_done = 0;
        n_cmp    = 0;
        n_err    = 0;
        wr(0, 8'h80); wr(1, 8'h95); wr(2, 8'h03); wr(3, 8'h1D);
        wr(4, 8'hC3); wr(5, 8'hA1); wr(6, 8'h7E); wr(7, 8'h04);
        fork
            monitor();
        join_none

        repeat (3) @(posedge CLOCK);
        #1;
        outs_zero("reset");
        @(posedge CLOCK); #3;
        RESET = 1'b1;

        // 1: default frame, latency and frame length
        push_frame(16'h8095, 16'h031D, 16'hC3A1, 16'h7E04);
        start();
        chk("re_b_latency", 32'(RE_B), 32'd1);
        chk("first_addr", 32'(ADD_B), 32'd0);
        n = 1;
        while (!CFG_SCK && n < 100) begin
            @(posedge CLOCK); #1;
            n++;
        end
        chk("sck_latency", 32'(n), 32'(3 + BD));
        bn = n;
        while (BUSY && bn < 2000) begin
            @(posedge CLOCK); #1;
            if (BUSY) bn++;
        end
        chk("frame_len", 32'(bn), 32'(frame_cycles(NW, BD, GB)));
        repeat (3) @(posedge CLOCK);
        #1;
        idle_checks("t1");

        // 2: new word1 contents; writes mid-word do not disturb it
        wr(2, 8'h5A);
        wr(3, 8'hA5);
        push_frame(16'h8095, 16'h5AA5, 16'hC3A1, 16'h7E04);
        start();
        wait_rises(20);
        wr(2, 8'h00);
        wr(3, 8'h00);
        wait_frame();
        wr(2, 8'h5A);
        wr(3, 8'hA5);
        repeat (3) @(posedge CLOCK);
        #1;
        idle_checks("t2");

        // 3: START held high for the whole frame
        push_frame(16'h8095, 16'h5AA5, 16'hC3A1, 16'h7E04);
        @(posedge CLOCK); #1;
        START = 1'b1;
        @(posedge CLOCK); #1;
        n = 0;
        while (BUSY && n < 2000) begin
            @(posedge CLOCK); #1;
            n++;
        end
        START = 1'b0;
        repeat (10) @(posedge CLOCK);
        #1;
        idle_checks("t3");

        // 4: abort during bit 7 of word 1, then restart
        exp_addr.push_back(2'd0);
        exp_addr.push_back(2'd1);
        exp_word.push_back(16'h8095);
        start();
        wait_rises(24);
        n = 0;
        while (CFG_SCK && n < 100) begin
            @(posedge CLOCK); #1;
            n++;
        end
        ABORT = 1'b1;
        @(posedge CLOCK); #1;
        ABORT = 1'b0;
        outs_zero("abort");
        repeat (300) @(posedge CLOCK);
        #1;
        idle_checks("t4a");
        push_frame(16'h8095, 16'h5AA5, 16'hC3A1, 16'h7E04);
        start();
        chk("restart_re_b", 32'(RE_B), 32'd1);
        chk("restart_addr", 32'(ADD_B), 32'd0);
        wait_frame();
        repeat (3) @(posedge CLOCK);
        #1;
        idle_checks("t4b");

        // 5: asynchronous reset mid-SHIFT
        exp_addr.push_back(2'd0);
        start();
        wait_rises(5);
        #2;
        RESET = 1'b0;
        #1;
        outs_zero("async_rst");
        @(posedge CLOCK); #3;
        RESET = 1'b1;
        repeat (20) @(posedge CLOCK);
        #1;
        idle_checks("t5");

        // 6: START and ABORT together
        @(posedge CLOCK); #1;
        START = 1'b1;
        ABORT = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        ABORT = 1'b0;
        chk("start_abort_busy", 32'(BUSY), 32'd0);
        repeat (10) @(posedge CLOCK);
        #1;
        idle_checks("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
